// File: rtl/calc_ctrl.sv
// calc_ctrl: keypad calculator sequencer covering decimal entry, signed add/sub and chained operators.
// Define CALC_MUL_EN to enable key 12 and build the OPW-cycle shift-add multiplier.
module calc_ctrl #(
    parameter int ND  = 4,
    parameter int OPW = 14
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           key_vld,
    input  logic [3:0]     key_code,
    output logic [OPW-1:0] disp_val,
    output logic           disp_neg,
    output logic           err,
    output logic           busy,
    output logic           res_vld
);
    function automatic int pow10(input int n);
        int p;
        p = 1;
        for (int i = 0; i < n; i++) p = p * 10;
        return p;
    endfunction

    localparam logic [OPW-1:0] MAX     = OPW'(pow10(ND) - 1);
    localparam logic [OPW-1:0] DIG_LIM = OPW'(pow10(ND - 1));

    typedef enum logic [2:0] {ENTER_A, OP_WAIT, ENTER_B, CALC, RESULT, ERROR} state_t;
    typedef enum logic [1:0] {OP_ADD, OP_SUB, OP_MUL} op_t;

    state_t         state, state_nxt;
    op_t            op, op_nxt, chain_op, chain_op_nxt, key_op;
    logic [OPW-1:0] a_mag, a_mag_nxt, b, b_nxt, disp_val_nxt, dig_val;
    logic           a_neg, a_neg_nxt, chain, chain_nxt;
    logic           disp_neg_nxt, err_nxt, res_vld_nxt;
    logic           key_is_op, key_is_dig;

    always_comb begin
        key_op    = OP_ADD;
        key_is_op = 1'b0;
        case (key_code)
            4'd10: begin key_op = OP_ADD; key_is_op = 1'b1; end
            4'd11: begin key_op = OP_SUB; key_is_op = 1'b1; end
`ifdef CALC_MUL_EN
            4'd12: begin key_op = OP_MUL; key_is_op = 1'b1; end
`endif
            default: ;
        endcase
    end

    assign key_is_dig = (key_code <= 4'd9);
    assign dig_val    = OPW'(key_code);

    // Add/sub in two's complement two bits wider than the operands, then back to sign-magnitude.
    logic signed [OPW+1:0] sa, sum, sabs;
    logic [OPW-1:0]        as_mag;
    logic                  as_neg, as_ovf;
    assign sa     = a_neg ? -$signed({2'b00, a_mag}) : $signed({2'b00, a_mag});
    assign sum    = (op == OP_SUB) ? sa - $signed({2'b00, b}) : sa + $signed({2'b00, b});
    assign as_neg = sum[OPW+1];
    assign sabs   = as_neg ? -sum : sum;
    assign as_mag = sabs[OPW-1:0];
    assign as_ovf = $unsigned(sabs) > {2'b00, MAX};

    logic           calc_done, res_neg, res_ovf;
    logic [OPW-1:0] res_mag;

`ifdef CALC_MUL_EN
    localparam int CW = $clog2(OPW);
    logic [2*OPW-1:0] mul_acc, mul_a, mul_acc_nxt;
    logic [OPW-1:0]   mul_b;
    logic [CW-1:0]    mul_cnt;

    assign mul_acc_nxt = mul_acc + (mul_b[0] ? mul_a : '0);

    // Operands track A/B while idle so the first CALC cycle already adds partial product 0.
    always_ff @(posedge clk) begin
        if (rst || state != CALC) begin
            mul_acc <= '0;
            mul_a   <= {{OPW{1'b0}}, a_mag};
            mul_b   <= b;
            mul_cnt <= '0;
        end else begin
            mul_acc <= mul_acc_nxt;
            mul_a   <= mul_a << 1;
            mul_b   <= mul_b >> 1;
            mul_cnt <= mul_cnt + 1'b1;
        end
    end

    always_comb begin
        calc_done = 1'b1;
        res_mag   = as_mag;
        res_neg   = as_neg;
        res_ovf   = as_ovf;
        if (op == OP_MUL) begin
            calc_done = (mul_cnt == CW'(OPW - 1));
            res_mag   = mul_acc_nxt[OPW-1:0];
            res_neg   = a_neg && (mul_acc_nxt != '0);
            res_ovf   = mul_acc_nxt > {{OPW{1'b0}}, MAX};
        end
    end
`else
    assign calc_done = 1'b1;
    assign res_mag   = as_mag;
    assign res_neg   = as_neg;
    assign res_ovf   = as_ovf;
`endif

    assign busy = (state == CALC);

    always_comb begin
        state_nxt    = state;
        op_nxt       = op;
        chain_nxt    = chain;
        chain_op_nxt = chain_op;
        a_mag_nxt    = a_mag;
        a_neg_nxt    = a_neg;
        b_nxt        = b;
        disp_val_nxt = disp_val;
        disp_neg_nxt = disp_neg;
        err_nxt      = err;
        res_vld_nxt  = 1'b0;
        if (key_vld && key_code == 4'd14) begin
            state_nxt    = ENTER_A;
            op_nxt       = OP_ADD;
            chain_nxt    = 1'b0;
            a_mag_nxt    = '0;
            a_neg_nxt    = 1'b0;
            b_nxt        = '0;
            disp_val_nxt = '0;
            disp_neg_nxt = 1'b0;
            err_nxt      = 1'b0;
        end else begin
            case (state)
                ENTER_A: if (key_vld) begin
                    if (key_is_dig && a_mag < DIG_LIM) begin
                        a_mag_nxt    = a_mag * OPW'(10) + dig_val;
                        disp_val_nxt = a_mag * OPW'(10) + dig_val;
                        disp_neg_nxt = a_neg;
                    end else if (key_is_op) begin
                        op_nxt    = key_op;
                        state_nxt = OP_WAIT;
                    end
                end
                OP_WAIT: if (key_vld) begin
                    if (key_is_dig) begin
                        b_nxt        = dig_val;
                        disp_val_nxt = dig_val;
                        disp_neg_nxt = 1'b0;
                        state_nxt    = ENTER_B;
                    end else if (key_is_op) begin
                        op_nxt = key_op;
                    end
                end
                ENTER_B: if (key_vld) begin
                    if (key_is_dig && b < DIG_LIM) begin
                        b_nxt        = b * OPW'(10) + dig_val;
                        disp_val_nxt = b * OPW'(10) + dig_val;
                        disp_neg_nxt = 1'b0;
                    end else if (key_code == 4'd13) begin
                        state_nxt = CALC;
                    end else if (key_is_op) begin
                        chain_nxt    = 1'b1;
                        chain_op_nxt = key_op;
                        state_nxt    = CALC;
                    end
                end
                CALC: if (calc_done) begin
                    chain_nxt = 1'b0;
                    if (res_ovf) begin
                        err_nxt      = 1'b1;
                        disp_val_nxt = '0;
                        disp_neg_nxt = 1'b0;
                        state_nxt    = ERROR;
                    end else begin
                        a_mag_nxt    = res_mag;
                        a_neg_nxt    = res_neg;
                        disp_val_nxt = res_mag;
                        disp_neg_nxt = res_neg;
                        res_vld_nxt  = 1'b1;
                        state_nxt    = chain ? OP_WAIT : RESULT;
                        if (chain) op_nxt = chain_op;
                    end
                end
                RESULT: if (key_vld) begin
                    if (key_is_dig) begin
                        a_mag_nxt    = dig_val;
                        a_neg_nxt    = 1'b0;
                        disp_val_nxt = dig_val;
                        disp_neg_nxt = 1'b0;
                        state_nxt    = ENTER_A;
                    end else if (key_is_op) begin
                        op_nxt    = key_op;
                        state_nxt = OP_WAIT;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ENTER_A;
            op       <= OP_ADD;
            chain    <= 1'b0;
            chain_op <= OP_ADD;
            a_mag    <= '0;
            a_neg    <= 1'b0;
            b        <= '0;
            disp_val <= '0;
            disp_neg <= 1'b0;
            err      <= 1'b0;
            res_vld  <= 1'b0;
        end else begin
            state    <= state_nxt;
            op       <= op_nxt;
            chain    <= chain_nxt;
            chain_op <= chain_op_nxt;
            a_mag    <= a_mag_nxt;
            a_neg    <= a_neg_nxt;
            b        <= b_nxt;
            disp_val <= disp_val_nxt;
            disp_neg <= disp_neg_nxt;
            err      <= err_nxt;
            res_vld  <= res_vld_nxt;
        end
    end
endmodule

// File: tb/tb_calc_ctrl.sv
// Scoreboard bench for calc_ctrl: expected results queued at '='/chained operator, checked on res_vld.
module tb_calc_ctrl;
    localparam int OPW = 14;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           key_vld = 1'b0;
    logic [3:0]     key_code = 4'd0;
    logic [OPW-1:0] disp_val;
    logic           disp_neg, err, busy, res_vld;

    calc_ctrl #(.ND(4), .OPW(OPW)) dut (
        .clk(clk), .rst(rst), .key_vld(key_vld), .key_code(key_code),
        .disp_val(disp_val), .disp_neg(disp_neg), .err(err), .busy(busy), .res_vld(res_vld)
    );

    always #5 clk = ~clk;

    typedef struct { int mag; int neg; } exp_t;
    exp_t sb[$];
    int   n_chk = 0, n_err = 0, rv_cnt = 0;

    task automatic chk(input string tag, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (res_vld) begin
            rv_cnt++;
            if (sb.size() > 0) begin
                exp_t e;
                e = sb.pop_front();
                chk("res_val", int'(disp_val), e.mag);
                chk("res_neg", int'(disp_neg), e.neg);
            end else begin
                chk("res_unexpected", 1, 0);
            end
        end
    end

    task automatic press(input int c);
        key_code = 4'(c);
        key_vld  = 1'b1;
        @(negedge clk);
        key_vld  = 1'b0;
    endtask

    task automatic push(input int mag, input int neg);
        exp_t e;
        e.mag = mag;
        e.neg = neg;
        sb.push_back(e);
    endtask

    // Returns busy cycles from the current negedge; ends one negedge after busy drops.
    task automatic wait_calc(output int cyc);
        cyc = 0;
        while (busy === 1'b1 && cyc < 64) begin
            cyc++;
            @(negedge clk);
        end
        if (cyc >= 64) chk("calc_timeout", cyc, 0);
        @(negedge clk);
    endtask

    int cyc, rv0;

    initial begin
        key_vld  = 1'b1;
        key_code = 4'd5;
        @(negedge clk);
        @(negedge clk);
        chk("rst_disp", int'(disp_val), 0);
        chk("rst_neg", int'(disp_neg), 0);
        chk("rst_err", int'(err), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_rv", int'(res_vld), 0);
        key_vld = 1'b0;
        rst     = 1'b0;
        @(negedge clk);

        // 12 + 34
        rv0 = rv_cnt;
        press(1); press(2);
        chk("enter_a", int'(disp_val), 12);
        press(10); press(3); press(4);
        chk("enter_b", int'(disp_val), 34);
        push(46, 0);
        press(13);
        wait_calc(cyc);
        chk("add_busy", cyc, 1);
        chk("add_rv_cnt", rv_cnt - rv0, 1);
        chk("rv_single", int'(res_vld), 0);

        // 5 - 9 then chain +10
        press(5);
        chk("restart_a", int'(disp_val), 5);
        press(11); press(9);
        push(4, 1);
        press(13);
        wait_calc(cyc);
        press(10); press(1); press(0);
        push(6, 0);
        press(13);
        wait_calc(cyc);
        chk("chain_neg_val", int'(disp_val), 6);

        // digit limit, overflow, error lock, clear
        press(9); press(9); press(9); press(9); press(9);
        chk("digit_limit", int'(disp_val), 9999);
        rv0 = rv_cnt;
        press(10); press(1); press(13);
        wait_calc(cyc);
        chk("ovf_err", int'(err), 1);
        chk("ovf_disp", int'(disp_val), 0);
        chk("ovf_neg", int'(disp_neg), 0);
        chk("ovf_no_rv", rv_cnt - rv0, 0);
        press(3);
        chk("err_lock_disp", int'(disp_val), 0);
        chk("err_lock_err", int'(err), 1);
        press(14);
        chk("clr_err", int'(err), 0);
        chk("clr_disp", int'(disp_val), 0);

        // 2 + 3 - 4 with chained operator
        rv0 = rv_cnt;
        press(2); press(10); press(3);
        push(5, 0);
        press(11);
        wait_calc(cyc);
        press(4);
        chk("chain_b", int'(disp_val), 4);
        push(1, 0);
        press(13);
        wait_calc(cyc);
        chk("chain_rv_cnt", rv_cnt - rv0, 2);

`ifdef CALC_MUL_EN
        // 123 x 45 with a dropped digit mid-CALC
        press(1); press(2); press(3); press(12); press(4); press(5);
        push(5535, 0);
        press(13);
        press(7);
        chk("mul_busy_mid", int'(busy), 1);
        wait_calc(cyc);
        chk("mul_busy", cyc + 1, 14);
        chk("mul_hold", int'(disp_val), 5535);

        // abort multiply with C
        rv0 = rv_cnt;
        press(9); press(9); press(12); press(9); press(9); press(9);
        press(13);
        press(1);
        press(14);
        chk("abort_busy", int'(busy), 0);
        chk("abort_disp", int'(disp_val), 0);
        repeat (16) @(negedge clk);
        chk("abort_no_rv", rv_cnt - rv0, 0);
        press(8);
        chk("abort_enter_a", int'(disp_val), 8);
`else
        // key 12 is inert: subsequent digit still appends to A
        press(7); press(12);
        chk("k12_disp", int'(disp_val), 7);
        chk("k12_busy", int'(busy), 0);
        press(8);
        chk("k12_state", int'(disp_val), 78);
`endif

        // reset together with a key press
        rst      = 1'b1;
        key_vld  = 1'b1;
        key_code = 4'd3;
        @(negedge clk);
        chk("rstkey_disp", int'(disp_val), 0);
        chk("rstkey_neg", int'(disp_neg), 0);
        chk("rstkey_err", int'(err), 0);
        chk("rstkey_busy", int'(busy), 0);
        chk("rstkey_rv", int'(res_vld), 0);
        rst     = 1'b0;
        key_vld = 1'b0;
        @(negedge clk);

        chk("sb_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/calc_ctrl.md
# calc_ctrl

Operation sequencer for the keypad calculator.
- Consumes one decoded key event per press from the keypad scan/debounce stage.
- Accumulates decimal operands and sequences add, subtract and (optionally) multiply operations.
- Presents a signed binary value to the display formatter.
- Owns all calculator state; the scanner below it and the BCD/7-seg driver above it are stateless with respect to arithmetic.

## Interface
Parameters:
- ND, 4: max decimal digits per operand; MAX = 10^ND − 1
- OPW, 14: operand/result magnitude width; must satisfy 2^OPW > MAX

Ports:
- clk  in  1  system clock; one clock domain
- rst  in  1  reset, synchronous, active-high
- key_vld  in  1  one-cycle pulse, key_code valid
- key_code  in  4  0–9 digit, 10 '+', 11 '−', 12 '×', 13 '=', 14 'C', 15 reserved
- disp_val  out  OPW  magnitude to display
- disp_neg  out  1  sign of disp_val
- err  out  1  overflow latched
- busy  out  1  arithmetic in progress; keys dropped
- res_vld  out  1  one-cycle pulse when a result is written to disp_val

## Operation
States:
- ENTER_A
- OP_WAIT
- ENTER_B
- CALC
- RESULT
- ERROR

Rules:
- Digit d, ENTER_A/ENTER_B: if the operand holds fewer than ND digits, operand = operand·10 + d and disp shows the operand (disp_neg = sign of A in ENTER_A, 0 in ENTER_B). At ND digits the key is ignored.
- Digit in OP_WAIT: B = d, go to ENTER_B.
- Digit in RESULT: A = d, sign +, go to ENTER_A.
- Operator in ENTER_A/RESULT: store op, A keeps the current value (signed), go to OP_WAIT.
- Operator in OP_WAIT: replaces the stored op.
- Operator in ENTER_B: behaves as '=' with the new op queued. After CALC completes, the result becomes A and the state is OP_WAIT, not RESULT.
- '=' in ENTER_B: go to CALC. '=' in any other state is ignored.
- 'C' in any state, CALC included: A = B = 0, op cleared, err = 0, go to ENTER_A. An aborted CALC produces no res_vld.
- Code 15: always ignored.
- Arithmetic is signed-magnitude on A (B is always non-negative). The result is signed; −0 displays as +0.
- Overflow: if |result| > MAX, go to ERROR with err = 1, disp_val = 0, disp_neg = 0. Only 'C' leaves ERROR.
- key_vld while busy (CALC): dropped, no state change, except 'C'.

## Timing
- Reset: all outputs 0; state ENTER_A; A = B = 0.
- Key effects are visible on disp_* the cycle after key_vld.
- Add/sub: CALC occupies exactly 1 cycle (busy = 1). The result and res_vld appear on the next cycle.
- Multiply: shift-add over B's OPW bits, so CALC lasts OPW cycles (14 by default). busy is high throughout. res_vld pulses on the cycle disp_val updates.
- Overflow is detected at CALC completion. On overflow res_vld does not pulse and err rises on the same cycle disp would have updated.
- key_vld and rst in the same cycle: rst wins.

## Configuration
- CALC_MUL_EN defined: key 12 is an operator, and the multi-cycle shift-add multiplier is instantiated.
- CALC_MUL_EN undefined: key 12 is ignored in every state, no multiplier logic is built, and CALC is always 1 cycle.

## Test plan
- Reset, keys 1,2,+,3,4,= → disp_val 46, disp_neg 0, res_vld one pulse, busy high for exactly 1 cycle.
- Keys 5,−,9,= → disp_val 4, disp_neg 1. Then +,1,0,= → disp_val 6, disp_neg 0 (chaining from a negative A).
- Keys 9,9,9,9,9 → disp_val 9999 (5th digit ignored). Then +,1,= → err 1, disp_val 0, no res_vld. Then digit 3 is ignored. Then 'C' → err 0, disp_val 0.
- CALC_MUL_EN defined: keys 1,2,3,×,4,5,= → busy high 14 cycles, disp_val 5535. A digit pressed mid-CALC is dropped.
- CALC_MUL_EN defined: keys 9,9,×,9,9,9 then 'C' mid-CALC → ENTER_A, disp_val 0, no res_vld. Without the macro, key 12 leaves state and disp unchanged.
- Keys 2,+,3,− (chained op) then 4,= → disp_val 1 with two res_vld pulses (5, then 1). rst asserted together with key_vld → all outputs 0.
